// File: rtl/definitions.sv
// Shared types and widths for the execute stage and its register-file interface.
package definitions;

    localparam int RegWidth     = 8;
    localparam int RegAddrWidth = 5;
    localparam int ShAmtWidth   = $clog2(RegWidth);
    localparam int CntWidth     = ShAmtWidth + 1;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } Signal;

    typedef logic [RegWidth-1:0]     Register;
    typedef logic [RegAddrWidth-1:0] RegAddr;
    typedef logic [CntWidth-1:0]     IterCount;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLT = 4'd5,
        SHL = 4'd6,
        SHR = 4'd7,
        MUL = 4'd8
    } AluOp;

    // State literals carry an EX_ prefix so they do not collide with AluOp's MUL.
    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_WB   = 2'd2
    } ExState;

    function automatic Signal to_signal(input logic b);
        return b ? ENABLE : DISABLE;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU for the single-cycle operations; MUL is handled elsewhere.
module alu_comb
    import definitions::*;
(
    input  AluOp    op,
    input  Register a,
    input  Register b,
    output Register y
);

    logic [ShAmtWidth-1:0] shamt_s;

    assign shamt_s = b[ShAmtWidth-1:0];

    // Result select; unsupported codes (including MUL) yield zero.
    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            SLT:     y = ($signed(a) < $signed(b)) ? Register'(1) : Register'(0);
            SHL:     y = a << shamt_s;
            SHR:     y = a >> shamt_s;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add MUL, delivering
// each result as a one-cycle register-file write pulse.
module execute_unit
    import definitions::*;
(
    input  logic    clk,
    input  Signal   reset,
    input  Signal   start,
    input  AluOp    op,
    input  Register rs_val,
    input  Register rt_val,
    input  RegAddr  rd_addr,
    output Signal   ready,
    output Signal   busy,
    output Signal   write,
    output RegAddr  wr_addr,
    output Register wr_data
);

    ExState   state_q, state_d;
    Signal    ready_q, ready_d;
    Signal    busy_q, busy_d;
    Signal    write_q, write_d;
    RegAddr   wr_addr_q, wr_addr_d;
    Register  wr_data_q, wr_data_d;
    RegAddr   rd_q, rd_d;
    Register  mcand_q, mcand_d;
    Register  mplier_q, mplier_d;
    Register  acc_q, acc_d;
    IterCount cnt_q, cnt_d;

    Register  alu_y_s;
    Register  acc_next_s;
    logic     accept_s;
    logic     last_iter_s;

    alu_comb u_alu (
        .op (op),
        .a  (rs_val),
        .b  (rt_val),
        .y  (alu_y_s)
    );

    assign accept_s    = (start == ENABLE) && ((state_q == EX_IDLE) || (state_q == EX_WB));
    assign last_iter_s = (cnt_q == IterCount'(1));
    assign acc_next_s  = acc_q + (mplier_q[0] ? mcand_q : Register'(0));

    // State register and registered status/strobe outputs; reset wins over start.
    always_ff @(posedge clk) begin
        if (reset == ENABLE) begin
            state_q <= EX_IDLE;
            ready_q <= ENABLE;
            busy_q  <= DISABLE;
            write_q <= DISABLE;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            write_q <= write_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EX_IDLE, EX_WB: begin
                if (accept_s) begin
                    state_d = (op == MUL) ? EX_MUL : EX_WB;
                end else begin
                    state_d = EX_IDLE;
                end
            end
            EX_MUL: begin
                if (last_iter_s) begin
                    state_d = EX_WB;
                end else begin
                    state_d = EX_MUL;
                end
            end
            default: state_d = EX_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they are registered alongside it.
    always_comb begin
        ready_d = to_signal((state_d == EX_IDLE) || (state_d == EX_WB));
        busy_d  = to_signal(state_d == EX_MUL);
        write_d = to_signal(state_d == EX_WB);
    end

    // Datapath registers: operands, multiplier iteration state and write payload.
    always_ff @(posedge clk) begin
        if (reset == ENABLE) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_q      <= rd_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Datapath next values; the write payload only changes when entering WB.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_d      = rd_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (accept_s) begin
            rd_d = rd_addr;
            if (op == MUL) begin
                mcand_d  = rs_val;
                mplier_d = rt_val;
                acc_d    = '0;
                cnt_d    = IterCount'(RegWidth);
            end else begin
                wr_addr_d = rd_addr;
                wr_data_d = alu_y_s;
            end
        end else if (state_q == EX_MUL) begin
            acc_d    = acc_next_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - IterCount'(1);
            if (last_iter_s) begin
                wr_addr_d = rd_q;
                wr_data_d = acc_next_s;
            end else begin
                wr_data_d = wr_data_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign write   = write_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage feeding the register-file write port. Takes a decoded operation plus the two source operands read from the register file (`rs_o`, `rt_o`) and computes the result. Single-cycle ALU operations finish in one cycle; `MUL` is a multi-cycle shift-add operation. The result is then delivered as a one-cycle write pulse (`write`, `wr_addr`, `wr_data`) that drives the register file's `write`, `rd`, and `rd_i` inputs.

## Interface
Parameters:
- none; all widths come from package `definitions`: `RegWidth` (data width, power of two), `RegAddrWidth`, `ShAmtWidth = $clog2(RegWidth)`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  `Signal`  synchronous, active-high (`ENABLE`); returns block to idle
- `start`  in  `Signal`  issue request; sampled only when `ready` is `ENABLE`
- `op`  in  `AluOp`  operation: `ADD`, `SUB`, `AND`, `OR`, `XOR`, `SLT`, `SHL`, `SHR`, `MUL`
- `rs_val`  in  `Register`  operand A
- `rt_val`  in  `Register`  operand B
- `rd_addr`  in  `RegAddr`  destination register
- `ready`  out  `Signal`  unit can accept `start` this cycle
- `busy`  out  `Signal`  a `MUL` is iterating
- `write`  out  `Signal`  one-cycle write strobe to the register file
- `wr_addr`  out  `RegAddr`  destination address, valid with `write`
- `wr_data`  out  `Register`  result, valid with `write`

## Operation
- States: `IDLE`, `MUL`, `WB`.
- Issue is accepted when `start == ENABLE` and the state is `IDLE` or `WB`. On acceptance, `rd_addr` is latched.
- Single-cycle ops (everything except `MUL`): the result is computed combinationally and registered on acceptance; the next state is `WB`.
- `MUL` on acceptance:
  - latch multiplicand = `rs_val` and multiplier = `rt_val`;
  - clear the accumulator;
  - load the iteration counter with `RegWidth`;
  - next state is `MUL`.
- `MUL` state, each cycle:
  - if multiplier LSB = 1, add the multiplicand to the accumulator;
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - decrement the counter.
  - When the counter reaches 1, the final iteration's result is registered and the next state is `WB`.
- `WB`: `write = ENABLE` for exactly one cycle. Next state:
  - `MUL` if a new `MUL` is accepted this cycle;
  - `WB` if a new single-cycle op is accepted this cycle;
  - otherwise `IDLE`.
- Arithmetic rules:
  - all results are truncated modulo 2^`RegWidth`; no overflow or carry flag;
  - `SUB` = `rs_val - rt_val`;
  - `SLT` is a signed two's-complement compare; the result is 1 or 0, zero-extended;
  - `SHL`/`SHR` are logical shifts by `rt_val[ShAmtWidth-1:0]`; upper bits of `rt_val` are ignored;
  - `MUL` yields the low `RegWidth` bits of the product.
- Output rules:
  - `ready` = (state is `IDLE` or `WB`);
  - `busy` = (state is `MUL`);
  - `wr_addr`/`wr_data` hold their last values outside `WB`;
  - writes to any address, including 0, are permitted.
- Reset values: state `IDLE`, `write = DISABLE`, `ready = ENABLE`, `busy = DISABLE`, `wr_addr = 0`, `wr_data = 0`, counter 0.
- Reset mid-operation (in `MUL` or `WB`): the operation is abandoned, no write is issued in the following cycle, and reset has priority over `start`.
- `start` while `busy`: ignored; the caller must hold the request until `ready`.

## Timing
- Single-cycle op: issue at edge N → `write` high in cycle N+1.
- `MUL`: issue at edge N → `busy` high for `RegWidth` cycles → `write` high in cycle N+1+`RegWidth`.
- Back-to-back single-cycle ops give one write per cycle (`WB` → `WB`).
- Operands are sampled only on the accepting edge. Register-file read data may change afterward without effect.
- A register-file write and a dependent read in the same cycle are resolved by the register file, not by this block. This unit does no forwarding.

## Structure
- Add to `definitions`:
  - `AluOp` enum;
  - `RegWidth` and `ShAmtWidth` constants;
  - `ExState` enum (`IDLE`, `MUL`, `WB`).
- Sub-module `alu_comb`: a purely combinational block for the single-cycle ops, with inputs `op`, `a`, `b` and output `y`. The FSM, multiplier datapath, and output registers live in `execute_unit`.

## Test plan
The bench uses `RegWidth = 8`.
- Reset, then idle: `ready = 1`, `busy = 0`, `write = 0`, `wr_data = 0` for 5 cycles.
- `ADD` `rs = 0xF0`, `rt = 0x20`, `rd = 3` → one cycle later `write = 1`, `wr_addr = 3`, `wr_data = 0x10`. `write` is 0 on the next cycle.
- `SLT` `0xFF` vs `0x01` → `wr_data = 0x01`. `SHR` `0x80` by `rt = 0x0B` → `wr_data = 0x10` (shift amount 3).
- `MUL` `0x0D × 0x0B` → `busy = 1` for 8 cycles, `ready = 0` throughout, then `write` with `wr_data = 0x8F`. A `start` pulsed mid-multiply is ignored.
- Back-to-back `XOR`, `OR`, `SUB` on consecutive cycles → three consecutive write pulses with correct addresses and data.
- `reset` asserted in the 4th `MUL` cycle → next cycle state is `IDLE`, `write = 0`, `wr_data = 0`, and no write occurs afterward.
